// File: rtl/serial_link_pkg.sv
// Shared definitions for the 4-bit serial link (PISO transmitter / deserializer).
package serial_link_pkg;

   localparam int DEFAULT_WORD_WIDTH = 4;

   typedef enum logic {
      HUNT  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage : serial_link_pkg

// File: rtl/word_hold_reg.sv
// One-entry valid/ready holding register. A load is accepted when the slot is
// empty or drains in the same cycle; otherwise the incoming word is dropped and
// reported on drop for the caller's sticky overrun flag.
module word_hold_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             drop
);

   logic accept;

   // Slot can take a word if empty or being consumed this cycle.
   always_comb begin
      accept = !valid || ready;
      drop   = load && !accept;
   end

   // Load on accept, otherwise clear valid after a transfer; data holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (load && accept) begin
         data  <= load_data;
         valid <= 1'b1;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule : word_hold_reg

// File: rtl/serial_word_deserializer.sv
// Receive stage of the serial link: assembles MSB-first bits sampled on bit_en
// into WIDTH-bit words, aligned by sync, and hands them to a 1-entry output
// register. Reports framing faults (sync mid-word) and overruns.
module serial_word_deserializer
   import serial_link_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WORD_WIDTH,
   parameter bit CONTINUOUS = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             serial_in,
   input  logic             bit_en,
   input  logic             sync,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun,
   input  logic             clr_overrun,
   output logic             frame_err,
   output logic             busy
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] asm_q, asm_d, shifted;
   logic             frame_err_d;
   logic             word_done;
   logic             drop;

   // Word as it would look with the current bit shifted in.
   assign shifted = {asm_q[WIDTH-2:0], serial_in};

   // State, bit counter, assembly register and registered flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= HUNT;
         cnt_q     <= '0;
         asm_q     <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         asm_q     <= asm_d;
         frame_err <= frame_err_d;
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop)
            overrun <= 1'b1;
         else if (clr_overrun)
            overrun <= 1'b0;
      end
   end

   // Next-state: hunt for sync, then shift bits and detect word end / resync.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      asm_d       = asm_q;
      frame_err_d = 1'b0;
      word_done   = 1'b0;
      case (state_q)
         HUNT: begin
            if (bit_en && sync) begin
               state_d = SHIFT;
               asm_d   = shifted;
               cnt_d   = CW'(1);
            end
         end
         SHIFT: begin
            if (bit_en) begin
               if (sync && cnt_q != '0) begin
                  // Resync mid-word: throw away the partial word, restart at this MSB.
                  frame_err_d = 1'b1;
                  asm_d       = {{(WIDTH-1){1'b0}}, serial_in};
                  cnt_d       = CW'(1);
               end else begin
                  asm_d = shifted;
                  if (cnt_q == LAST) begin
                     word_done = 1'b1;
                     cnt_d     = '0;
                     if (!CONTINUOUS)
                        state_d = HUNT;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // Busy only while a partial word is pending (not at a word boundary).
   always_comb begin
      busy = (state_q == SHIFT) && (cnt_q != '0);
   end

   word_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (word_done),
      .load_data (shifted),
      .ready     (out_ready),
      .data      (out_data),
      .valid     (out_valid),
      .drop      (drop)
   );

endmodule : serial_word_deserializer
